// File: rtl/scanner_serial_tx.sv
// Scanner serial transmitter: buffers up to DEPTH samples, then shifts them out MSB-first on a divided clock.
// Optional build macro PARITY_EN appends an even-parity bit to every word.
module scanner_serial_tx #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   cmd,
    input  logic [DATA_W-1:0]            sampleIn,
    input  logic                         sampleValid,
    input  logic                         readyForTransferIn,
    output logic                         clkOut,
    output logic                         dataOut,
    output logic                         frameOut,
    output logic                         readyForTransferOut,
    output logic                         commandDoneBit,
    output logic [2:0]                   ps,
    output logic [$clog2(DEPTH+1)-1:0]   wordCount,
    output logic                         overflow
);

    // Handshake: readyForTransferOut advertises pending data in WAIT; readyForTransferIn
    // grants the transfer and, during XFER, must be high for the low phase of clkOut to advance.
    localparam int CW = $clog2(DEPTH+1);
    localparam int MEM_N = 1 << CW;
`ifdef PARITY_EN
    localparam int FRAME = DATA_W + 1;
`else
    localparam int FRAME = DATA_W;
`endif
    localparam int BIT_W = $clog2(FRAME+1);
    localparam int DIV_W = $clog2(CLK_DIV+1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SCAN = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] XFER = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        ns;
    logic [DATA_W-1:0] mem [MEM_N];
    logic [DIV_W-1:0]  divCnt;
    logic [BIT_W-1:0]  bitIdx;
    logic [CW-1:0]     wordIdx;
    logic [CW-1:0]     countNext;
    logic              abort, divDone, riseTick, fallTick, lastBit;
    logic [BIT_W-1:0]  nxtBitIdx;
    logic [CW-1:0]     nxtWordIdx;
    logic [DATA_W-1:0] nxtWord, shifted;
    logic              nxtData;

    assign abort     = (cmd == 2'b10);
    assign countNext = wordCount + CW'(sampleValid);
    assign divDone   = (divCnt == DIV_W'(CLK_DIV-1));
    assign riseTick  = (ps == XFER) && !clkOut && readyForTransferIn && divDone;
    assign fallTick  = (ps == XFER) && clkOut && divDone;
    assign lastBit   = (bitIdx == BIT_W'(FRAME-1)) && (wordIdx == wordCount - CW'(1));

    // Position and value of the bit presented after the current falling toggle.
    always_comb begin
        nxtBitIdx  = bitIdx + BIT_W'(1);
        nxtWordIdx = wordIdx;
        if (bitIdx == BIT_W'(FRAME-1)) begin
            nxtBitIdx  = '0;
            nxtWordIdx = wordIdx + CW'(1);
        end
        nxtWord = mem[nxtWordIdx];
        shifted = nxtWord << nxtBitIdx;
`ifdef PARITY_EN
        nxtData = (nxtBitIdx == BIT_W'(DATA_W)) ? ^nxtWord : shifted[DATA_W-1];
`else
        nxtData = shifted[DATA_W-1];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ps <= IDLE;
        else      ps <= ns;
    end

    always_comb begin
        ns = ps;
        case (ps)
            IDLE: if (cmd == 2'b01) ns = SCAN;
            SCAN: begin
                if (countNext == CW'(DEPTH))  ns = WAIT;
                else if (cmd == 2'b11)        ns = (countNext != '0) ? WAIT : DONE;
            end
            WAIT: if (readyForTransferIn) ns = XFER;
            XFER: if (fallTick && lastBit) ns = DONE;
            DONE: ns = IDLE;
            default: ns = IDLE;
        endcase
        if (abort) ns = IDLE;
    end

    always_comb begin
        frameOut            = (ps == XFER);
        readyForTransferOut = (ps == WAIT);
        commandDoneBit      = (ps == DONE);
    end

    // Buffer contents need no reset.
    always_ff @(posedge clk) begin
        if (ps == SCAN && sampleValid && !abort) mem[wordCount] <= sampleIn;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clkOut    <= 1'b0;
            dataOut   <= 1'b0;
            divCnt    <= '0;
            bitIdx    <= '0;
            wordIdx   <= '0;
            wordCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (sampleValid && (ps == WAIT || ps == XFER || ps == DONE)) overflow <= 1'b1;
            if (abort) begin
                clkOut    <= 1'b0;
                dataOut   <= 1'b0;
                divCnt    <= '0;
                bitIdx    <= '0;
                wordIdx   <= '0;
                wordCount <= '0;
            end else begin
                case (ps)
                    IDLE: if (cmd == 2'b01) begin
                        wordCount <= '0;
                        overflow  <= 1'b0;
                    end
                    SCAN: if (sampleValid) wordCount <= countNext;
                    WAIT: if (readyForTransferIn) begin
                        clkOut  <= 1'b0;
                        divCnt  <= '0;
                        bitIdx  <= '0;
                        wordIdx <= '0;
                        dataOut <= mem[0][DATA_W-1];
                    end
                    XFER: begin
                        if (riseTick) begin
                            clkOut <= 1'b1;
                            divCnt <= '0;
                        end else if (fallTick) begin
                            clkOut <= 1'b0;
                            divCnt <= '0;
                            if (lastBit) begin
                                dataOut <= 1'b0;
                            end else begin
                                bitIdx  <= nxtBitIdx;
                                wordIdx <= nxtWordIdx;
                                dataOut <= nxtData;
                            end
                        end else if (clkOut || readyForTransferIn) begin
                            divCnt <= divCnt + DIV_W'(1);
                        end
                    end
                    DONE: begin
                        wordCount <= '0;
                        clkOut    <= 1'b0;
                        dataOut   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scanner_serial_tx.sv
// Directed-plus-random bench for scanner_serial_tx (DATA_W=4, DEPTH=2, CLK_DIV=2) with a bit-stream reference model.
module tb_scanner_serial_tx;

    localparam int DATA_W  = 4;
    localparam int DEPTH   = 2;
    localparam int CLK_DIV = 2;
    localparam int CW      = $clog2(DEPTH+1);
`ifdef PARITY_EN
    localparam int FRAME = DATA_W + 1;
`else
    localparam int FRAME = DATA_W;
`endif

    logic              clk, rst;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] sampleIn;
    logic              sampleValid, readyForTransferIn;
    logic              clkOut, dataOut, frameOut, readyForTransferOut, commandDoneBit;
    logic [2:0]        ps;
    logic [CW-1:0]     wordCount;
    logic              overflow;

    int n_cmp = 0;
    int n_fail = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    logic prev_clk = 1'b0;
    logic [0:0]        exp_q[$];
    logic [0:0]        cap_q[$];
    logic [DATA_W-1:0] word_q[$];

    scanner_serial_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .sampleIn(sampleIn), .sampleValid(sampleValid),
        .readyForTransferIn(readyForTransferIn), .clkOut(clkOut), .dataOut(dataOut),
        .frameOut(frameOut), .readyForTransferOut(readyForTransferOut),
        .commandDoneBit(commandDoneBit), .ps(ps), .wordCount(wordCount), .overflow(overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Observe serial outputs just after each clk edge.
    always @(posedge clk) begin
        #1;
        if (frameOut) xfer_cnt++;
        if (commandDoneBit) done_cnt++;
        if (clkOut && !prev_clk) cap_q.push_back(dataOut);
        else if (clkOut && prev_clk && frameOut) chk("hold_high", dataOut, cap_q[$]);
        prev_clk = clkOut;
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] c);
        cmd = c;
        tick();
        cmd = 2'b00;
    endtask

    task automatic write_word(input logic [DATA_W-1:0] v, input logic [1:0] c);
        sampleValid = 1'b1;
        sampleIn    = v;
        cmd         = c;
        tick();
        sampleValid = 1'b0;
        cmd         = 2'b00;
    endtask

    task automatic clear_obs();
        cap_q.delete();
        xfer_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ps == 3'd0) begin
                ok = 1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    // One full scan/transfer of the words in word_q, with an optional grant stall after bit 0.
    task automatic do_frame(input bit flush_same, input int stall);
        int n = word_q.size();
        bit found = 0;
        exp_q.delete();
        foreach (word_q[k]) begin
            for (int b = DATA_W-1; b >= 0; b--) exp_q.push_back(word_q[k][b]);
`ifdef PARITY_EN
            exp_q.push_back(1'($countones(word_q[k]) % 2));
`endif
        end
        send_cmd(2'b01);
        chk("scan_entry", 32'(ps), 32'd1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        for (int k = 0; k < n; k++)
            write_word(word_q[k], (flush_same && k == n-1) ? 2'b11 : 2'b00);
        if (!flush_same) send_cmd(2'b11);
        chk("wait_state", 32'(ps), 32'd2);
        chk("wait_ready", 32'(readyForTransferOut), 32'd1);
        chk("wait_count", 32'(wordCount), 32'(n));
        clear_obs();
        readyForTransferIn = 1'b1;
        if (stall > 0) begin
            for (int i = 0; i < 200; i++) begin
                tick();
                if (cap_q.size() == 1 && !clkOut) begin
                    found = 1;
                    break;
                end
            end
            chk("stall_reach", 32'(found), 32'd1);
            readyForTransferIn = 1'b0;
            repeat (stall) tick();
            chk("stall_clk_low", 32'(clkOut), 32'd0);
            chk("stall_data_hold", 32'(dataOut), 32'(exp_q[1]));
            chk("stall_no_rise", 32'(cap_q.size()), 32'd1);
            readyForTransferIn = 1'b1;
        end
        wait_idle(2000);
        readyForTransferIn = 1'b0;
        chk("xfer_len", 32'(xfer_cnt), 32'(2*CLK_DIV*FRAME*n + stall));
        chk("done_pulse", 32'(done_cnt), 32'd1);
        chk("bit_count", 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk($sformatf("bit%0d", i), 32'(cap_q[i]), 32'(exp_q[i]));
        chk("end_count", 32'(wordCount), 32'd0);
        chk("end_clk", 32'(clkOut), 32'd0);
        chk("end_data", 32'(dataOut), 32'd0);
        chk("end_frame", 32'(frameOut), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        cmd = 2'b00;
        sampleIn = '0;
        sampleValid = 1'b0;
        readyForTransferIn = 1'b0;
        tick();
        chk("rst_ps", 32'(ps), 32'd0);
        chk("rst_outs", {26'd0, clkOut, dataOut, frameOut, readyForTransferOut, commandDoneBit, overflow}, 32'd0);
        chk("rst_count", 32'(wordCount), 32'd0);
        rst = 1'b1;
        tick();

        // full buffer, fixed words
        word_q = '{4'hA, 4'h5};
        do_frame(1'b0, 0);

        // partial buffer, separate flush
        word_q = '{4'h3};
        do_frame(1'b0, 0);

        // flush with an empty buffer
        send_cmd(2'b01);
        clear_obs();
        send_cmd(2'b11);
        chk("empty_done_ps", 32'(ps), 32'd4);
        chk("empty_done_bit", 32'(commandDoneBit), 32'd1);
        tick();
        chk("empty_idle_ps", 32'(ps), 32'd0);
        chk("empty_done_once", 32'(done_cnt), 32'd1);
        chk("empty_no_clk", 32'(cap_q.size()), 32'd0);

        // grant withdrawn for 10 cycles
        word_q = '{4'hA, 4'h5};
        do_frame(1'b0, 10);

        // randomized frames
        for (int it = 0; it < 5; it++) begin
            int n = $urandom_range(1, DEPTH);
            word_q.delete();
            for (int k = 0; k < n; k++) word_q.push_back(DATA_W'($urandom));
            do_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? $urandom_range(1, 12) : 0);
        end

        // abort mid-transfer
        send_cmd(2'b01);
        write_word(DATA_W'($urandom), 2'b00);
        write_word(DATA_W'($urandom), 2'b00);
        readyForTransferIn = 1'b1;
        repeat (7) tick();
        chk("abort_in_xfer", 32'(frameOut), 32'd1);
        clear_obs();
        send_cmd(2'b10);
        chk("abort_ps", 32'(ps), 32'd0);
        chk("abort_outs", {29'd0, clkOut, dataOut, frameOut}, 32'd0);
        chk("abort_count", 32'(wordCount), 32'd0);
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        readyForTransferIn = 1'b0;

        // overflow and ignored commands in WAIT
        send_cmd(2'b01);
        write_word(4'h1, 2'b00);
        write_word(4'h2, 2'b00);
        write_word(4'hF, 2'b00);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(wordCount), 32'd2);
        send_cmd(2'b11);
        send_cmd(2'b01);
        chk("wait_ignores_cmds", 32'(ps), 32'd2);
        send_cmd(2'b10);
        chk("ovf_abort_ps", 32'(ps), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        send_cmd(2'b01);
        chk("ovf_start_clear", 32'(overflow), 32'd0);
        send_cmd(2'b10);

        // asynchronous reset during the high phase of clkOut
        send_cmd(2'b01);
        write_word(4'hC, 2'b00);
        write_word(4'h9, 2'b00);
        readyForTransferIn = 1'b1;
        for (int i = 0; i < 100 && !clkOut; i++) tick();
        chk("pre_rst_clk_high", 32'(clkOut), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_ps", 32'(ps), 32'd0);
        chk("arst_outs", {26'd0, clkOut, dataOut, frameOut, readyForTransferOut, commandDoneBit, overflow}, 32'd0);
        chk("arst_count", 32'(wordCount), 32'd0);
        readyForTransferIn = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
